axi4lite_slave_regs: RTL and testbench
======================================

Name: axi4lite_slave_regs

Overview:
AXI4-Lite responder (slave end) with a bank of NUM_REGS memory-mapped DATAWIDTH-bit registers. It is the completer counterpart to the team's AXI4-Lite master. Write and read channels run independent FSMs built on the axi4lite_pkg state enum (IDLE, ADDR, DATA, RESP). ADDRWIDTH and DATAWIDTH come from axi4lite_pkg.

Parameters:
ADDRWIDTH, axi4lite_pkg::ADDRWIDTH (32), address bus width
DATAWIDTH, axi4lite_pkg::DATAWIDTH (32), data bus width; only 32 is supported
NUM_REGS, 16, number of 32-bit registers; power of two, 2..256

Ports:
ACLK  in  1  single clock, rising edge
ARESET  in  1  asynchronous, active-high reset
AWADDR  in  ADDRWIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATAWIDTH  write data
WSTRB  in  DATAWIDTH/8  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDRWIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATAWIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset, asynchronous: both FSMs go to IDLE and all registers clear to 0.
  - While ARESET is high, all outputs are 0, including every READY.
  - READYs may assert from the first ACLK edge after deassertion.
- Address decode: index = addr[ADDRWIDTH-1:2]; addr[1:0] is ignored.
  - In range: index < NUM_REGS. Otherwise out of range.
- Write FSM (AWREADY = state in {IDLE, DATA}; WREADY = state in {IDLE, ADDR}):
  - IDLE, AWVALID & WVALID: capture both, commit the write, go to RESP.
  - IDLE, AWVALID only: capture the address, go to ADDR.
  - IDLE, WVALID only: capture data and strobes, go to DATA.
  - ADDR, WVALID: commit the write, go to RESP.
  - DATA, AWVALID: commit the write, go to RESP.
  - Commit happens on the edge that completes the second handshake. For each byte i with WSTRB[i]=1, reg[index] byte i takes WDATA byte i.
  - Out-of-range commit: no register changes; BRESP=10.
  - RESP: BVALID=1 with BRESP stable until a BREADY edge, then go to IDLE with BVALID=0.
  - No new AW/W is accepted in RESP, so at most one write is outstanding.
- Read FSM (ARREADY = state==IDLE; the ADDR and RESP states are unused):
  - IDLE, ARVALID: sample reg[index] into RDATA, go to DATA with RVALID=1.
  - Read latency is 1 cycle after the AR handshake.
  - Out of range: RDATA=0, RRESP=10.
  - DATA: RDATA, RRESP and RVALID are held until an RREADY edge, then go to IDLE.
  - RVALID and RDATA are registered.
- Simultaneous events:
  - A read handshake on the same edge as a write commit to the same register returns the old value. The next read returns the new value.
  - Read and write channels never stall each other.
- Ready and valid rules:
  - VALID outputs never drop before their handshake.
  - The block ignores master VALID deassertion without a handshake, since AXI forbids it.
  - BREADY/RREADY held high give back-to-back throughput: one write per 2 cycles, one read per 2 cycles.
- Reset mid-transaction: the in-flight transaction is discarded and the partially captured address/data is lost. The register contents clear.

Test Plan:
1. Write AW+W same cycle: addr 0x08, data 0xDEADBEEF, WSTRB 0xF, BREADY=1. Required: BVALID exactly 1 cycle after the handshake with BRESP=00. Then read 0x08: RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR.
2. W three cycles before AW: W 0x12345678 to addr 0x04. Required: WREADY drops after the W handshake; AWREADY stays high; the write commits on the AW edge; readback is 0x12345678.
3. Partial strobe: reg 0x0C preset to 0xFFFFFFFF, write 0x00000000 with WSTRB=0101. Required: readback 0xFF00FF00.
4. Out of range, NUM_REGS=16: write to 0x40, then read 0x40. Required: BRESP=10, RRESP=10, RDATA=0; a full scan shows no register changed.
5. Backpressure: hold BREADY=0 for 5 cycles, then RREADY=0 for 5 cycles. Required: BVALID and RVALID with their data stay stable; AWREADY and ARREADY stay low until the handshake completes.
6. Simultaneous edge: read 0x00 on the same edge a write of 0xA5 to 0x00 commits. Required: RDATA=0 (old value); the following read returns 0xA5. Then assert ARESET mid-read. Required: all outputs 0 immediately; reg 0x00 reads 0 after release.

Source files
------------

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS memory-mapped 32-bit registers.
// Write and read channels run independent FSMs; at most one write and one read are in flight.
package axi4lite_pkg;
   localparam int ADDRWIDTH = 32;
   localparam int DATAWIDTH = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } axi_state_t;
endpackage

module axi4lite_slave_regs #(
   parameter int ADDRWIDTH = axi4lite_pkg::ADDRWIDTH,
   parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH,
   parameter int NUM_REGS  = 16
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic [ADDRWIDTH-1:0]   AWADDR,
   input  logic                   AWVALID,
   output logic                   AWREADY,
   input  logic [DATAWIDTH-1:0]   WDATA,
   input  logic [DATAWIDTH/8-1:0] WSTRB,
   input  logic                   WVALID,
   output logic                   WREADY,
   output logic [1:0]             BRESP,
   output logic                   BVALID,
   input  logic                   BREADY,
   input  logic [ADDRWIDTH-1:0]   ARADDR,
   input  logic                   ARVALID,
   output logic                   ARREADY,
   output logic [DATAWIDTH-1:0]   RDATA,
   output logic [1:0]             RRESP,
   output logic                   RVALID,
   input  logic                   RREADY
);
   import axi4lite_pkg::axi_state_t;
   import axi4lite_pkg::IDLE;
   import axi4lite_pkg::ADDR;
   import axi4lite_pkg::DATA;
   import axi4lite_pkg::RESP;
   import axi4lite_pkg::RESP_OKAY;
   import axi4lite_pkg::RESP_SLVERR;

   localparam int STRBW  = DATAWIDTH / 8;
   localparam int IDXW   = $clog2(NUM_REGS);
   localparam int WADDRW = ADDRWIDTH - 2;

   // Word address: byte offset bits [1:0] never take part in decode.
   function automatic logic f_in_range(input logic [WADDRW-1:0] a);
      return (a >> IDXW) == '0;
   endfunction

   function automatic logic [IDXW-1:0] f_index(input logic [WADDRW-1:0] a);
      return a[IDXW-1:0];
   endfunction

   axi_state_t           r_wstate;
   axi_state_t           w_wstate_nxt;
   axi_state_t           r_rstate;
   axi_state_t           w_rstate_nxt;

   logic                 r_rdy_en;
   logic [WADDRW-1:0]    r_awaddr;
   logic [DATAWIDTH-1:0] r_wdata;
   logic [STRBW-1:0]     r_wstrb;
   logic [1:0]           r_bresp;
   logic [DATAWIDTH-1:0] r_rdata;
   logic [1:0]           r_rresp;
   logic [DATAWIDTH-1:0] r_regs [NUM_REGS];

   logic [WADDRW-1:0]    w_aw_word;
   logic [WADDRW-1:0]    w_ar_word;
   logic                 w_awready;
   logic                 w_wready;
   logic                 w_arready;
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_commit;
   logic [WADDRW-1:0]    w_cm_addr;
   logic [DATAWIDTH-1:0] w_cm_data;
   logic [STRBW-1:0]     w_cm_strb;
   logic                 w_unused_addr_lsbs;

   assign w_aw_word          = AWADDR[ADDRWIDTH-1:2];
   assign w_ar_word          = ARADDR[ADDRWIDTH-1:2];
   assign w_unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

   // Readies stay low during reset and until the first edge after release.
   assign w_awready = r_rdy_en && (r_wstate == IDLE || r_wstate == DATA);
   assign w_wready  = r_rdy_en && (r_wstate == IDLE || r_wstate == ADDR);
   assign w_arready = r_rdy_en && (r_rstate == IDLE);

   assign w_aw_hs = AWVALID && w_awready;
   assign w_w_hs  = WVALID && w_wready;
   assign w_ar_hs = ARVALID && w_arready;

   assign AWREADY = w_awready;
   assign WREADY  = w_wready;
   assign ARREADY = w_arready;
   assign BVALID  = (r_wstate == RESP);
   assign BRESP   = r_bresp;
   assign RVALID  = (r_rstate == DATA);
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rdy_en <= 1'b0;
         r_wstate <= IDLE;
         r_rstate <= IDLE;
      end else begin
         r_rdy_en <= 1'b1;
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_commit     = 1'b0;
      w_cm_addr    = r_awaddr;
      w_cm_data    = r_wdata;
      w_cm_strb    = r_wstrb;
      case (r_wstate)
         IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_commit     = 1'b1;
               w_cm_addr    = w_aw_word;
               w_cm_data    = WDATA;
               w_cm_strb    = WSTRB;
               w_wstate_nxt = RESP;
            end else if (w_aw_hs) begin
               w_wstate_nxt = ADDR;
            end else if (w_w_hs) begin
               w_wstate_nxt = DATA;
            end
         end
         ADDR: begin
            if (w_w_hs) begin
               w_commit     = 1'b1;
               w_cm_data    = WDATA;
               w_cm_strb    = WSTRB;
               w_wstate_nxt = RESP;
            end
         end
         DATA: begin
            if (w_aw_hs) begin
               w_commit     = 1'b1;
               w_cm_addr    = w_aw_word;
               w_wstate_nxt = RESP;
            end
         end
         RESP: begin
            if (BREADY) w_wstate_nxt = IDLE;
         end
         default: w_wstate_nxt = IDLE;
      endcase
   end

   // Read channel only ever visits IDLE and DATA.
   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         IDLE:    if (w_ar_hs) w_rstate_nxt = DATA;
         DATA:    if (RREADY) w_rstate_nxt = IDLE;
         default: w_rstate_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bresp  <= RESP_OKAY;
      end else begin
         if (w_aw_hs) r_awaddr <= w_aw_word;
         if (w_w_hs) begin
            r_wdata <= WDATA;
            r_wstrb <= WSTRB;
         end
         if (w_commit) r_bresp <= f_in_range(w_cm_addr) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // NOTE: the register bank is cleared by reset because software relies on zeroed contents.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_commit && f_in_range(w_cm_addr)) begin
         for (int b = 0; b < STRBW; b++) begin
            if (w_cm_strb[b]) r_regs[f_index(w_cm_addr)][b*8 +: 8] <= w_cm_data[b*8 +: 8];
         end
      end
   end

   // Sampling r_regs here sees the pre-commit value when a write lands on the same edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         if (f_in_range(w_ar_word)) begin
            r_rdata <= r_regs[f_index(w_ar_word)];
            r_rresp <= RESP_OKAY;
         end else begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench: a transaction-level register model checked every cycle,
// plus directed AXI4-Lite scenarios with hand-computed expectations.
module tb_axi4lite_slave_regs;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int TMO = 50;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic [AW-1:0] AWADDR = '0;
   logic          AWVALID = 1'b0;
   logic          AWREADY;
   logic [DW-1:0] WDATA = '0;
   logic [3:0]    WSTRB = '0;
   logic          WVALID = 1'b0;
   logic          WREADY;
   logic [1:0]    BRESP;
   logic          BVALID;
   logic          BREADY = 1'b0;
   logic [AW-1:0] ARADDR = '0;
   logic          ARVALID = 1'b0;
   logic          ARREADY;
   logic [DW-1:0] RDATA;
   logic [1:0]    RRESP;
   logic          RVALID;
   logic          RREADY = 1'b0;

   always #5 ACLK = ~ACLK;

   axi4lite_slave_regs #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_REGS(NR)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: register array plus outstanding-response bookkeeping.
   logic [31:0] m_regs [NR];
   bit          m_rdy_ok, m_b_pend, m_r_pend, m_aw_held, m_w_held;
   logic [1:0]  m_bresp, m_rresp;
   logic [31:0] m_rdata, m_awaddr, m_wdata;
   logic [3:0]  m_wstrb;

   always @(posedge ACLK) if (!ARESET) m_rdy_ok = 1'b1;

   always @(negedge ACLK) begin
      if (ARESET) begin
         check("reset_outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}, '0);
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
         {m_rdy_ok, m_b_pend, m_r_pend, m_aw_held, m_w_held} = '0;
      end else begin
         if (m_rdy_ok) begin
            check("awready", AWREADY, !m_b_pend && !m_aw_held);
            check("wready", WREADY, !m_b_pend && !m_w_held);
            check("arready", ARREADY, !m_r_pend);
         end
         check("bvalid", BVALID, m_b_pend);
         if (m_b_pend) check("bresp", BRESP, m_bresp);
         check("rvalid", RVALID, m_r_pend);
         if (m_r_pend) begin
            check("rdata", RDATA, m_rdata);
            check("rresp", RRESP, m_rresp);
         end
         // Predict what the coming rising edge does.
         if (m_b_pend && BREADY) m_b_pend = 1'b0;
         if (m_r_pend && RREADY) m_r_pend = 1'b0;
         if (ARVALID && ARREADY) begin
            if ((ARADDR >> 2) < NR) begin
               m_rdata = m_regs[ARADDR[5:2]];
               m_rresp = 2'b00;
            end else begin
               m_rdata = '0;
               m_rresp = 2'b10;
            end
            m_r_pend = 1'b1;
         end
         if (AWVALID && AWREADY) begin
            m_aw_held = 1'b1;
            m_awaddr  = AWADDR;
         end
         if (WVALID && WREADY) begin
            m_w_held = 1'b1;
            m_wdata  = WDATA;
            m_wstrb  = WSTRB;
         end
         if (m_aw_held && m_w_held) begin
            if ((m_awaddr >> 2) < NR) begin
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_regs[m_awaddr[5:2]][b*8 +: 8] = m_wdata[b*8 +: 8];
               m_bresp = 2'b00;
            end else begin
               m_bresp = 2'b10;
            end
            m_b_pend  = 1'b1;
            m_aw_held = 1'b0;
            m_w_held  = 1'b0;
         end
      end
   end

   // Tasks start and end one time unit after a rising edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold, output logic [1:0] resp);
      int k;
      BREADY = (hold == 0);
      fork
         begin
            int ka;
            if (aw_dly > 0) begin repeat (aw_dly) @(posedge ACLK); #1; end
            AWADDR = addr; AWVALID = 1'b1;
            ka = 0;
            @(negedge ACLK);
            while (!AWREADY && ka < TMO) begin @(negedge ACLK); ka++; end
            check("aw_handshake_wait", AWREADY, 1'b1);
            @(posedge ACLK); #1;
            AWVALID = 1'b0;
         end
         begin
            int kw;
            if (w_dly > 0) begin repeat (w_dly) @(posedge ACLK); #1; end
            WDATA = data; WSTRB = strb; WVALID = 1'b1;
            kw = 0;
            @(negedge ACLK);
            while (!WREADY && kw < TMO) begin @(negedge ACLK); kw++; end
            check("w_handshake_wait", WREADY, 1'b1);
            @(posedge ACLK); #1;
            WVALID = 1'b0;
         end
      join
      k = 0;
      @(negedge ACLK);
      while (!BVALID && k < TMO) begin @(negedge ACLK); k++; end
      check("bvalid_wait", BVALID, 1'b1);
      resp = BRESP;
      if (hold > 0) begin
         repeat (hold) @(posedge ACLK);
         #1 BREADY = 1'b1;
         @(negedge ACLK);
      end
      @(posedge ACLK); #1;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int k;
      RREADY = (hold == 0);
      ARADDR = addr; ARVALID = 1'b1;
      k = 0;
      @(negedge ACLK);
      while (!ARREADY && k < TMO) begin @(negedge ACLK); k++; end
      check("ar_handshake_wait", ARREADY, 1'b1);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      k = 0;
      @(negedge ACLK);
      while (!RVALID && k < TMO) begin @(negedge ACLK); k++; end
      check("rvalid_wait", RVALID, 1'b1);
      data = RDATA;
      resp = RRESP;
      if (hold > 0) begin
         repeat (hold) @(posedge ACLK);
         #1 RREADY = 1'b1;
         @(negedge ACLK);
      end
      @(posedge ACLK); #1;
   endtask

   logic [31:0] rd;
   logic [1:0]  rr, br;
   logic [31:0] scan_exp [NR];

   initial begin
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(posedge ACLK); #1;

      // 1: AW and W together, then read back.
      axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
      check("t1_bresp", br, 2'b00);
      axi_read(32'h08, 0, rd, rr);
      check("t1_rdata", rd, 32'hDEADBEEF);
      check("t1_rresp", rr, 2'b00);

      // 2: W three cycles ahead of AW.
      BREADY = 1'b1;
      WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
      @(negedge ACLK);
      check("t2_wready_first", WREADY, 1'b1);
      @(posedge ACLK); #1 WVALID = 1'b0;
      repeat (2) begin
         @(negedge ACLK);
         check("t2_wready_low", WREADY, 1'b0);
         check("t2_awready_high", AWREADY, 1'b1);
         check("t2_no_bvalid", BVALID, 1'b0);
         @(posedge ACLK); #1;
      end
      AWADDR = 32'h04; AWVALID = 1'b1;
      @(negedge ACLK);
      check("t2_awready", AWREADY, 1'b1);
      @(posedge ACLK); #1 AWVALID = 1'b0;
      @(negedge ACLK);
      check("t2_bvalid", BVALID, 1'b1);
      check("t2_bresp", BRESP, 2'b00);
      @(posedge ACLK); #1;
      axi_read(32'h04, 0, rd, rr);
      check("t2_rdata", rd, 32'h12345678);

      // 3: partial strobes clear bytes 0 and 2 only.
      axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, br);
      axi_write(32'h0C, 32'h00000000, 4'b0101, 0, 0, 0, br);
      axi_read(32'h0C, 0, rd, rr);
      check("t3_rdata", rd, 32'hFF00FF00);

      // Last register via an unaligned address, AW ahead of W.
      axi_write(32'h3E, 32'h0BADCAFE, 4'hF, 0, 2, 0, br);
      check("top_reg_bresp", br, 2'b00);
      axi_read(32'h3F, 0, rd, rr);
      check("top_reg_rdata", rd, 32'h0BADCAFE);

      // 4: out-of-range accesses.
      axi_write(32'h40, 32'h11111111, 4'hF, 0, 0, 0, br);
      check("t4_bresp", br, 2'b10);
      axi_read(32'h40, 0, rd, rr);
      check("t4_rdata", rd, 32'h0);
      check("t4_rresp", rr, 2'b10);
      axi_read(32'h80000000, 0, rd, rr);
      check("t4_high_rresp", rr, 2'b10);
      for (int i = 0; i < NR; i++) scan_exp[i] = '0;
      scan_exp[1]  = 32'h12345678;
      scan_exp[2]  = 32'hDEADBEEF;
      scan_exp[3]  = 32'hFF00FF00;
      scan_exp[15] = 32'h0BADCAFE;
      for (int i = 0; i < NR; i++) begin
         axi_read(32'(i * 4), 0, rd, rr);
         check($sformatf("t4_scan_%0d", i), {rr, rd}, {2'b00, scan_exp[i]});
      end

      // 5: backpressure on both response channels.
      axi_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 5, br);
      check("t5_bresp", br, 2'b00);
      axi_read(32'h10, 5, rd, rr);
      check("t5_rdata", rd, 32'hCAFEF00D);

      // 6: read and write commit on the same edge, then reset mid-read.
      fork
         axi_write(32'h00, 32'h000000A5, 4'hF, 0, 0, 0, br);
         axi_read(32'h00, 0, rd, rr);
      join
      check("t6_old_value", rd, 32'h0);
      axi_read(32'h00, 0, rd, rr);
      check("t6_new_value", rd, 32'h000000A5);
      ARADDR = 32'h00; ARVALID = 1'b1; RREADY = 1'b0;
      @(negedge ACLK);
      @(posedge ACLK); #1 ARVALID = 1'b0;
      @(negedge ACLK);
      check("t6_rvalid_before_reset", RVALID, 1'b1);
      @(posedge ACLK); #1 ARESET = 1'b1;
      #1 check("t6_reset_outputs_now", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA}, '0);
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      axi_read(32'h00, 0, rd, rr);
      check("t6_after_reset_r0", rd, 32'h0);
      axi_read(32'h08, 0, rd, rr);
      check("t6_after_reset_r2", rd, 32'h0);

      repeat (2) @(posedge ACLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by t=%0t, want $finish earlier", $time);
      $fatal(1);
   end
endmodule
